// File: rtl/nv_ram_rwsp_256x16_fifo_ctl.sv
// Valid/ready FIFO controller around a 256x16 two-port RAM with a two-stage
// (re/ore) read pipeline and a 3-entry skid buffer that absorbs in-flight data.
module nv_ram_rwsp_256x16_fifo_ctl #(
  parameter int unsigned AW   = 8,
  parameter int unsigned DW   = 16,
  parameter int unsigned SKID = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic [AW-1:0] ram_wa,
  output logic          ram_we,
  output logic [DW-1:0] ram_di,
  output logic [AW-1:0] ram_ra,
  output logic          ram_re,
  output logic          ram_ore,
  input  logic [DW-1:0] ram_dout,
  output logic [AW:0]   count
);

  localparam int unsigned CW  = AW + 1;
  localparam int unsigned SCW = $clog2(SKID + 1);
  localparam int unsigned OCW = SCW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(1) << AW;

  logic [AW-1:0]  wp_q, wp_d;
  logic [AW-1:0]  rp_q, rp_d;
  logic [CW-1:0]  ram_cnt_q, ram_cnt_d;
  logic [CW-1:0]  count_q, count_d;
  logic           s1_q, s2_q;
  logic [SCW-1:0] skid_cnt_q, skid_cnt_d;
  logic [DW-1:0]  skid_q [SKID];
  logic [DW-1:0]  skid_d [SKID];

  logic           wr_fire;
  logic           pop;
  logic           issue;
  logic           pop_skid;
  logic           push;
  logic [SCW-1:0] wr_idx;
  logic [OCW-1:0] occ;

  // Handshakes, read-issue credit check and all combinational outputs
  always_comb begin
    wr_prdy  = (ram_cnt_q != DEPTH);
    wr_fire  = wr_pvld & wr_prdy;
    ram_we   = wr_fire;
    ram_wa   = wp_q;
    ram_di   = wr_pd;

    rd_pvld  = (skid_cnt_q != '0) | s2_q;
    rd_pd    = (skid_cnt_q != '0) ? skid_q[0] : (s2_q ? ram_dout : '0);
    pop      = rd_pvld & rd_prdy;

    // Words outside the RAM after this cycle's pop must leave room for one more
    occ      = OCW'(skid_cnt_q) + OCW'(s1_q) + OCW'(s2_q) - OCW'(pop);
    issue    = (ram_cnt_q != '0) && (occ < OCW'(SKID));
    ram_re   = issue;
    ram_ra   = rp_q;
    ram_ore  = s1_q;
  end

  // Next-state for pointers, counters and the skid buffer (head at index 0)
  always_comb begin
    wp_d       = wr_fire ? wp_q + AW'(1) : wp_q;
    rp_d       = issue ? rp_q + AW'(1) : rp_q;
    ram_cnt_d  = ram_cnt_q + CW'(wr_fire) - CW'(issue);
    count_d    = count_q + CW'(wr_fire) - CW'(pop);

    pop_skid   = pop && (skid_cnt_q != '0);
    push       = s2_q && !(pop && (skid_cnt_q == '0));
    wr_idx     = skid_cnt_q - SCW'(pop_skid);
    skid_cnt_d = skid_cnt_q + SCW'(push) - SCW'(pop_skid);

    skid_d     = skid_q;
    if (pop_skid) begin
      for (int i = 0; i < int'(SKID) - 1; i++) begin
        skid_d[i] = skid_q[i+1];
      end
    end
    if (push) begin
      for (int i = 0; i < int'(SKID); i++) begin
        if (SCW'(i) == wr_idx) skid_d[i] = ram_dout;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q       <= '0;
      rp_q       <= '0;
      ram_cnt_q  <= '0;
      count_q    <= '0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      skid_cnt_q <= '0;
      for (int i = 0; i < int'(SKID); i++) skid_q[i] <= '0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      ram_cnt_q  <= ram_cnt_d;
      count_q    <= count_d;
      s1_q       <= issue;
      s2_q       <= s1_q;
      skid_cnt_q <= skid_cnt_d;
      skid_q     <= skid_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_nv_ram_rwsp_256x16_fifo_ctl.sv
// Directed bench for the RAM FIFO controller with a behavioural re/ore RAM.
module tb_nv_ram_rwsp_256x16_fifo_ctl;

  logic        clk;
  logic        rst;
  logic        wr_pvld;
  logic        wr_prdy;
  logic [15:0] wr_pd;
  logic        rd_pvld;
  logic        rd_prdy;
  logic [15:0] rd_pd;
  logic [7:0]  ram_wa;
  logic        ram_we;
  logic [15:0] ram_di;
  logic [7:0]  ram_ra;
  logic        ram_re;
  logic        ram_ore;
  logic [15:0] ram_dout;
  logic [8:0]  count;

  nv_ram_rwsp_256x16_fifo_ctl dut (
    .clk(clk), .rst(rst),
    .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
    .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
    .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di),
    .ram_ra(ram_ra), .ram_re(ram_re), .ram_ore(ram_ore),
    .ram_dout(ram_dout), .count(count)
  );

  // Two-port RAM: write port, latched read address, registered output
  logic [15:0] mem [256];
  logic [7:0]  ra_q;
  always @(posedge clk) begin
    if (ram_we)  mem[ram_wa] <= ram_di;
    if (ram_re)  ra_q <= ram_ra;
    if (ram_ore) ram_dout <= mem[ra_q];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk, n_fail;
  int n_wr, n_re, n_pop, first_pop, last_pop, cyc;
  int model_cnt, ram_model;
  logic [15:0] sbq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, observe settled outputs, update the model
  task automatic tick(input logic wv, input logic [15:0] wd, input logic rr);
    logic [15:0] exp_d;
    @(negedge clk);
    wr_pvld = wv; wr_pd = wd; rd_prdy = rr;
    #1;
    chk("count_model", 32'(count), 32'(model_cnt));
    chk("wr_prdy_full", 32'(wr_prdy), 32'(ram_model != 256));
    chk("outside_le3", 32'((model_cnt - ram_model) <= 3), 32'd1);
    if (ram_re) begin
      chk("issue_nonempty", 32'(ram_model > 0), 32'd1);
      n_re++; ram_model--;
    end
    if (wr_pvld && wr_prdy) begin
      sbq.push_back(wd);
      n_wr++; model_cnt++; ram_model++;
    end
    if (rd_pvld && rd_prdy) begin
      chk("pop_nonempty", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        exp_d = sbq.pop_front();
        chk("rd_pd_order", 32'(rd_pd), 32'(exp_d));
      end
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      n_pop++; model_cnt--;
    end
    cyc++;
  endtask

  // Reset for one cycle, check the cleared outputs, then clear the model
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wr_pvld = 1'b0; rd_prdy = 1'b0; wr_pd = '0;
    @(negedge clk);
    #1;
    chk("rst_wr_prdy", 32'(wr_prdy), 32'd1);
    chk("rst_rd_pvld", 32'(rd_pvld), 32'd0);
    chk("rst_rd_pd",   32'(rd_pd),   32'd0);
    chk("rst_count",   32'(count),   32'd0);
    chk("rst_ram_re",  32'(ram_re),  32'd0);
    chk("rst_ram_ore", 32'(ram_ore), 32'd0);
    chk("rst_ram_we",  32'(ram_we),  32'd0);
    rst = 1'b0;
    sbq.delete();
    model_cnt = 0; ram_model = 0;
    n_wr = 0; n_re = 0; n_pop = 0; first_pop = -1; last_pop = -1; cyc = 0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; wr_pvld = 1'b0; rd_prdy = 1'b0; wr_pd = '0;
    repeat (2) @(posedge clk);

    // Single word latency
    do_reset();
    tick(1'b1, 16'hA5A5, 1'b1);
    chk("sw_c0_we", 32'(ram_we), 32'd1);
    chk("sw_c0_rd_pvld", 32'(rd_pvld), 32'd0);
    tick(1'b0, 16'h0, 1'b1);
    chk("sw_c1_re", 32'(ram_re), 32'd1);
    chk("sw_c1_ra", 32'(ram_ra), 32'd0);
    chk("sw_c1_count", 32'(count), 32'd1);
    tick(1'b0, 16'h0, 1'b1);
    chk("sw_c2_ore", 32'(ram_ore), 32'd1);
    chk("sw_c2_re", 32'(ram_re), 32'd0);
    chk("sw_c2_rd_pvld", 32'(rd_pvld), 32'd0);
    tick(1'b0, 16'h0, 1'b1);
    chk("sw_c3_rd_pvld", 32'(rd_pvld), 32'd1);
    chk("sw_c3_rd_pd", 32'(rd_pd), 32'hA5A5);
    chk("sw_c3_count", 32'(count), 32'd1);
    tick(1'b0, 16'h0, 1'b1);
    chk("sw_c4_count", 32'(count), 32'd0);
    chk("sw_c4_rd_pvld", 32'(rd_pvld), 32'd0);

    // Fill with reader stalled
    do_reset();
    for (int i = 0; i < 300; i++) tick(1'b1, 16'(i), 1'b0);
    chk("fill_accepted", 32'(n_wr), 32'd259);
    chk("fill_re_pulses", 32'(n_re), 32'd3);
    chk("fill_wr_prdy", 32'(wr_prdy), 32'd0);
    chk("fill_count", 32'(count), 32'd259);

    // Drain after fill
    n_pop = 0; first_pop = -1; last_pop = -1;
    tick(1'b0, 16'h0, 1'b1);
    chk("drain_first_re", 32'(ram_re), 32'd1);
    chk("drain_first_wr_prdy", 32'(wr_prdy), 32'd0);
    chk("drain_first_rd_pd", 32'(rd_pd), 32'd0);
    tick(1'b0, 16'h0, 1'b1);
    chk("drain_wr_prdy_back", 32'(wr_prdy), 32'd1);
    for (int i = 0; i < 400 && n_pop < 259; i++) tick(1'b0, 16'h0, 1'b1);
    chk("drain_pops", 32'(n_pop), 32'd259);
    chk("drain_no_bubble", 32'(last_pop - first_pop), 32'd258);
    tick(1'b0, 16'h0, 1'b1);
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_rd_pvld", 32'(rd_pvld), 32'd0);

    // Streaming with pointer wrap
    do_reset();
    for (int i = 0; i < 1010; i++) tick(i < 1000, 16'(i + 16'h3000), 1'b1);
    chk("stream_writes", 32'(n_wr), 32'd1000);
    chk("stream_pops", 32'(n_pop), 32'd1000);
    chk("stream_first_pop", 32'(first_pop), 32'd3);
    chk("stream_continuous", 32'(last_pop - first_pop), 32'd999);
    chk("stream_count", 32'(count), 32'd0);

    // Random backpressure
    do_reset();
    for (int i = 0; i < 3000; i++)
      tick(1'($urandom_range(1)), 16'($urandom), 1'($urandom_range(1)));
    for (int i = 0; i < 400 && model_cnt != 0; i++) tick(1'b0, 16'h0, 1'b1);
    chk("rand_drained", 32'(model_cnt), 32'd0);
    tick(1'b0, 16'h0, 1'b1);
    chk("rand_count", 32'(count), 32'd0);
    chk("rand_sb_empty", 32'(sbq.size()), 32'd0);

    // Reset mid-operation
    do_reset();
    for (int i = 0; i < 100; i++) tick(1'b1, 16'(i + 16'h0100), 1'b0);
    tick(1'b1, 16'h0BAD, 1'b1);
    tick(1'b1, 16'h0BAD, 1'b1);
    do_reset();
    tick(1'b1, 16'h1234, 1'b1);
    tick(1'b0, 16'h0, 1'b1);
    chk("mid_c1_rd_pvld", 32'(rd_pvld), 32'd0);
    tick(1'b0, 16'h0, 1'b1);
    chk("mid_c2_rd_pvld", 32'(rd_pvld), 32'd0);
    tick(1'b0, 16'h0, 1'b1);
    chk("mid_c3_rd_pvld", 32'(rd_pvld), 32'd1);
    chk("mid_c3_rd_pd", 32'(rd_pd), 32'h1234);
    tick(1'b0, 16'h0, 1'b1);
    chk("mid_final_count", 32'(count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
